// File: rtl/bus_tristate_ctrl.sv
// Four-source round-robin tristate bus driver with a one-cycle turnaround between owners.
// Define BUS_KEEPER_EN to hold the last captured value on the bus while no source is enabled.
module bus_tristate_ctrl #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      grant,
  output logic [3:0]      bus_oe,
  inout  wire  [DW-1:0]   bus,
  output logic [DW-1:0]   rx_data,
  output logic            rx_valid,
  output logic [1:0]      rx_src
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_e;

  state_e          state_q;
  logic [1:0]      last_q;
  logic [1:0]      owner_q;
  logic [HW-1:0]   hold_q;
  logic [3:0]      grant_q;
  logic [DW-1:0]   rx_data_q;
  logic            rx_valid_q;
  logic [1:0]      rx_src_q;
  logic [1:0]      win_s;
  logic [DW-1:0]   drv_s;

  // Search last+1 .. last+3 then last; iterating downward lets the closest requester win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Arbitration winner and the data of the current owner.
  always_comb begin
    win_s = rr_pick(req, last_q);
    drv_s = din[int'(owner_q)*DW +: DW];
  end

  // Ownership FSM, round-robin pointer and bus capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 2'd3;
      owner_q    <= 2'd0;
      hold_q     <= '0;
      grant_q    <= 4'b0000;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_src_q   <= 2'd0;
    end else begin
      if (grant_q != 4'b0000) begin
        rx_data_q  <= drv_s;
        rx_src_q   <= owner_q;
        rx_valid_q <= 1'b1;
      end else begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_TURN: begin
          if (|req) begin
            state_q <= S_OWN;
            owner_q <= win_s;
            grant_q <= onehot(win_s);
            hold_q  <= HW'(1);
          end else begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            hold_q  <= '0;
          end
        end
        S_OWN: begin
          if (req[owner_q] && (hold_q < MAX_HOLD_C)) begin
            hold_q <= hold_q + HW'(1);
          end else begin
            // Recording the released owner as last puts it at the back of the queue.
            state_q <= S_TURN;
            grant_q <= 4'b0000;
            last_q  <= owner_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 4'b0000;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign bus_oe   = grant_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_src   = rx_src_q;

`ifdef BUS_KEEPER_EN
  logic [DW-1:0] keeper_q;

  // Keeper follows every capture so the idle bus shows the last owned value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keeper_q <= '0;
    end else if (grant_q != 4'b0000) begin
      keeper_q <= drv_s;
    end else begin
      keeper_q <= keeper_q;
    end
  end

  assign bus = (grant_q != 4'b0000) ? drv_s : keeper_q;
`else
  assign bus = (grant_q != 4'b0000) ? drv_s : {DW{1'bz}};
`endif

endmodule

// File: tb/tb_bus_tristate_ctrl.sv
// Directed bench for bus_tristate_ctrl: vector table plus reset, handover, fairness sequences.
module tb_bus_tristate_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req2;
  logic [31:0] din;
  logic [3:0]  grant, bus_oe, grant2, bus_oe2;
  wire  [7:0]  bus, bus2;
  logic [7:0]  rx_data, rx_data2;
  logic        rx_valid, rx_valid2;
  logic [1:0]  rx_src, rx_src2;

  int total = 0;
  int bad   = 0;

  bus_tristate_ctrl #(.DW(8), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .grant(grant), .bus_oe(bus_oe),
    .bus(bus), .rx_data(rx_data), .rx_valid(rx_valid), .rx_src(rx_src)
  );

  bus_tristate_ctrl #(.DW(8), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .din(din), .grant(grant2), .bus_oe(bus_oe2),
    .bus(bus2), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_src(rx_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] oe;
    logic       rxv;
    logic [7:0] rxd;
    logic [1:0] rxs;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_bus(input logic [3:0] oe);
    case (oe)
      4'b0001: exp_bus = 8'h5A;
      4'b0010: exp_bus = 8'h3C;
      4'b0100: exp_bus = 8'hA5;
      4'b1000: exp_bus = 8'hD3;
      default: exp_bus = 8'h00;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] oe, input logic v,
                              input logic [7:0] d, input logic [1:0] s);
    vec_t t;
    t.req = r; t.oe = oe; t.rxv = v; t.rxd = d; t.rxs = s;
    return t;
  endfunction

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] e_oe;
    rst_n = 1'b0;
    req   = 4'b1111;
    req2  = 4'b0000;
    din   = {8'hD3, 8'hA5, 8'h3C, 8'h5A};

    // Reset held with all sources requesting
    step(); step();
    chk("reset_oe", {28'd0, bus_oe}, 32'd0);
    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_rxv", {31'd0, rx_valid}, 32'd0);
    chk("reset_rxd", {24'd0, rx_data}, 32'd0);
    chk("reset_rxs", {30'd0, rx_src}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_grant", {28'd0, bus_oe}, 32'h1);

    // Vector table: single owner, release, same-cycle handover
    tbl[0]  = mk(4'b0100, 4'b0100, 1'b0, 8'h00, 2'd0);
    tbl[1]  = mk(4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[2]  = mk(4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[3]  = mk(4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[4]  = mk(4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[5]  = mk(4'b0000, 4'b0000, 1'b1, 8'hA5, 2'd2);
    tbl[6]  = mk(4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[7]  = mk(4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[8]  = mk(4'b0010, 4'b0010, 1'b0, 8'hA5, 2'd2);
    tbl[9]  = mk(4'b1001, 4'b0000, 1'b1, 8'h3C, 2'd1);
    tbl[10] = mk(4'b1001, 4'b1000, 1'b0, 8'h3C, 2'd1);
    tbl[11] = mk(4'b1000, 4'b1000, 1'b1, 8'hD3, 2'd3);
    tbl[12] = mk(4'b0001, 4'b0000, 1'b1, 8'hD3, 2'd3);
    tbl[13] = mk(4'b0001, 4'b0001, 1'b0, 8'hD3, 2'd3);
    tbl[14] = mk(4'b0000, 4'b0000, 1'b1, 8'h5A, 2'd0);
    tbl[15] = mk(4'b0000, 4'b0000, 1'b0, 8'h5A, 2'd0);

    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      step();
      chk($sformatf("vec%0d_oe", i), {28'd0, bus_oe}, {28'd0, tbl[i].oe});
      chk($sformatf("vec%0d_grant", i), {28'd0, grant}, {28'd0, tbl[i].oe});
      chk($sformatf("vec%0d_rxv", i), {31'd0, rx_valid}, {31'd0, tbl[i].rxv});
      chk($sformatf("vec%0d_rxd", i), {24'd0, rx_data}, {24'd0, tbl[i].rxd});
      chk($sformatf("vec%0d_rxs", i), {30'd0, rx_src}, {30'd0, tbl[i].rxs});
      if (tbl[i].oe != 4'b0000) begin
        chk($sformatf("vec%0d_bus", i), {24'd0, bus}, {24'd0, exp_bus(tbl[i].oe)});
      end
`ifdef BUS_KEEPER_EN
      else begin
        chk($sformatf("vec%0d_keeper", i), {24'd0, bus}, {24'd0, tbl[i].rxd});
      end
`endif
    end

    // Handover with MAX_HOLD=16: 16 owned, 1 dead, alternating 0 and 1
    req = 4'b0011;
    do_reset();
    for (int c = 0; c < 51; c++) begin
      step();
      e_oe = ((c % 17) == 16) ? 4'b0000 : (((c / 17) % 2 == 0) ? 4'b0001 : 4'b0010);
      chk($sformatf("handover_c%0d", c), {28'd0, bus_oe}, {28'd0, e_oe});
    end
    req = 4'b0000;

    // Fairness with MAX_HOLD=2: owners 0,1,2,3,0 with one dead cycle between
    req2 = 4'b1111;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step();
      e_oe = ((c % 3) == 2) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
      chk($sformatf("fair_c%0d", c), {28'd0, bus_oe2}, {28'd0, e_oe});
    end
    req2 = 4'b0000;

    // Reset during source 3 ownership clears enables without a clock edge
    req = 4'b1000;
    do_reset();
    step(); step(); step();
    chk("pre_rst_oe", {28'd0, bus_oe}, 32'h8);
    chk("pre_rst_rxv", {31'd0, rx_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {28'd0, bus_oe}, 32'd0);
    chk("async_rst_rxv", {31'd0, rx_valid}, 32'd0);
    req = 4'b1001;
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", {28'd0, bus_oe}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
